// File: rtl/mips_defs.sv
// Shared definitions for the MIPS decode/issue slice: opcodes, instruction
// field positions, issue FSM encoding and the decoded control bundle.
package mips_defs;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam int OP_HI    = 31;
    localparam int OP_LO    = 26;
    localparam int RS_HI    = 25;
    localparam int RS_LO    = 21;
    localparam int RT_HI    = 20;
    localparam int RT_LO    = 16;
    localparam int RD_HI    = 15;
    localparam int RD_LO    = 11;
    localparam int IMM_HI   = 15;
    localparam int FUNCT_HI = 5;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        WAIT  = 2'd2
    } state_t;

    typedef struct packed {
        logic regWrite;
        logic regDst;
        logic memRead;
        logic memWrite;
        logic memToReg;
        logic aluSrc;
        logic branch;
        logic jump;
        logic usesRs;
        logic usesRt;
        logic illegal;
    } ctrl_t;

endpackage

// File: rtl/decode_issue_stage_if.sv
// Register-file read and hazard-marking port between the ID stage (master)
// and the register file (slave).
interface decode_issue_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    logic [REG_AW-1:0] index1;
    logic [REG_AW-1:0] index2;
    logic [DATA_W-1:0] valueOutput1;
    logic [DATA_W-1:0] valueOutput2;
    logic              flagOutput1;
    logic              flagOutput2;
    logic              regWriteD;
    logic              regDstD;
    logic [REG_AW-1:0] RtD;
    logic [REG_AW-1:0] RdD;

    modport master (
        output index1, index2, regWriteD, regDstD, RtD, RdD,
        input  valueOutput1, valueOutput2, flagOutput1, flagOutput2
    );

    modport slave (
        input  index1, index2, regWriteD, regDstD, RtD, RdD,
        output valueOutput1, valueOutput2, flagOutput1, flagOutput2
    );
endinterface

// File: rtl/decode_issue_stage_control.sv
// Opcode-to-control decoder for the ID stage; purely combinational.
module control_decoder
    import mips_defs::*;
(
    input  logic [5:0] opcode,
    output ctrl_t      ctrl
);

    always_comb begin
        // NOTE: every field gets a default before the case, so no path can leave a latch behind.
        ctrl = '0;
        unique case (opcode)
            OP_RTYPE: begin
                ctrl.usesRs   = 1'b1;
                ctrl.usesRt   = 1'b1;
                ctrl.regDst   = 1'b1;
                ctrl.regWrite = 1'b1;
            end
            OP_ADDI: begin
                ctrl.usesRs   = 1'b1;
                ctrl.aluSrc   = 1'b1;
                ctrl.regWrite = 1'b1;
            end
            OP_LW: begin
                ctrl.usesRs   = 1'b1;
                ctrl.memRead  = 1'b1;
                ctrl.memToReg = 1'b1;
                ctrl.aluSrc   = 1'b1;
                ctrl.regWrite = 1'b1;
            end
            OP_SW: begin
                ctrl.usesRs   = 1'b1;
                ctrl.usesRt   = 1'b1;
                ctrl.memWrite = 1'b1;
                ctrl.aluSrc   = 1'b1;
            end
            OP_BEQ: begin
                ctrl.usesRs   = 1'b1;
                ctrl.usesRt   = 1'b1;
                ctrl.branch   = 1'b1;
            end
            OP_J: begin
                ctrl.jump     = 1'b1;
            end
            default: begin
                ctrl.illegal  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/decode_issue_stage.sv
// ID stage: IF/ID register, scoreboard-flag stall logic, issue FSM and the
// ID/EX pipeline register feeding execute.
module decode_issue_stage
    import mips_defs::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       instrF,
    input  logic [DATA_W-1:0] pcPlus4F,
    input  logic              validF,
    input  logic              flushD,
    output logic              stallF,
    decode_issue_stage_if.master rf,
    output logic              validE,
    output logic              regWriteE,
    output logic              regDstE,
    output logic              memReadE,
    output logic              memWriteE,
    output logic              memToRegE,
    output logic              aluSrcE,
    output logic              branchE,
    output logic              jumpE,
    output logic [DATA_W-1:0] rsValE,
    output logic [DATA_W-1:0] rtValE,
    output logic [DATA_W-1:0] immE,
    output logic [DATA_W-1:0] pcPlus4E,
    output logic [REG_AW-1:0] RtE,
    output logic [REG_AW-1:0] RdE,
    output logic [5:0]        functE,
    output logic              illegalD,
    output logic [CNT_W-1:0]  stallCountD
);

    state_t            state;
    state_t            stateNext;
    logic [31:0]       instrD;
    logic [DATA_W-1:0] pcPlus4D;
    ctrl_t             ctrl;
    logic              validD;
    logic              rsWait;
    logic              rtWait;
    logic              hazard;
    logic              fire;
    logic              issueD;
    logic              loadD;
    logic [REG_AW-1:0] rsD;
    logic [REG_AW-1:0] rtD;
    logic [REG_AW-1:0] rdD;
    logic [REG_AW-1:0] destD;

    assign rsD = instrD[RS_HI:RS_LO];
    assign rtD = instrD[RT_HI:RT_LO];
    assign rdD = instrD[RD_HI:RD_LO];

    control_decoder uDecoder (
        .opcode (instrD[OP_HI:OP_LO]),
        .ctrl   (ctrl)
    );

    // Register 0 is hardwired, so its pending flag is ignored.
    assign validD = (state != EMPTY);
    assign rsWait = ctrl.usesRs && (rsD != '0) && !rf.flagOutput1;
    assign rtWait = ctrl.usesRt && (rtD != '0) && !rf.flagOutput2;
    assign hazard = validD && (rsWait || rtWait);
    assign fire   = validD && !hazard && !flushD && !reset;
    assign issueD = fire && !ctrl.illegal;
    assign stallF = hazard && !flushD && !reset;
    assign destD  = ctrl.regDst ? rdD : rtD;

    assign rf.index1    = rsD;
    assign rf.index2    = rtD;
    assign rf.RtD       = rtD;
    assign rf.RdD       = rdD;
    assign rf.regWriteD = fire && ctrl.regWrite && (destD != '0);
    assign rf.regDstD   = fire && ctrl.regDst;

    always_comb begin
        stateNext = state;
        loadD     = 1'b0;
        unique case (state)
            EMPTY: begin
                if (validF && !flushD) begin
                    stateNext = FULL;
                    loadD     = 1'b1;
                end
            end
            FULL, WAIT: begin
                if (flushD) begin
                    stateNext = EMPTY;
                end else if (hazard) begin
                    stateNext = WAIT;
                end else begin
                    stateNext = validF ? FULL : EMPTY;
                    loadD     = validF;
                end
            end
            default: stateNext = EMPTY;
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= stateNext;
        end
    end

    // NOTE: the pipeline data registers are reset too, so the E outputs read 0 after reset rather than X.
    always_ff @(posedge clk) begin
        if (reset) begin
            instrD   <= '0;
            pcPlus4D <= '0;
        end else if (loadD) begin
            instrD   <= instrF;
            pcPlus4D <= pcPlus4F;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            validE    <= 1'b0;
            regWriteE <= 1'b0;
            regDstE   <= 1'b0;
            memReadE  <= 1'b0;
            memWriteE <= 1'b0;
            memToRegE <= 1'b0;
            aluSrcE   <= 1'b0;
            branchE   <= 1'b0;
            jumpE     <= 1'b0;
            rsValE    <= '0;
            rtValE    <= '0;
            immE      <= '0;
            pcPlus4E  <= '0;
            RtE       <= '0;
            RdE       <= '0;
            functE    <= '0;
        end else begin
            // Bubbles clear the control bits but leave the data fields as they were.
            validE    <= issueD;
            regWriteE <= issueD && ctrl.regWrite;
            regDstE   <= issueD && ctrl.regDst;
            memReadE  <= issueD && ctrl.memRead;
            memWriteE <= issueD && ctrl.memWrite;
            memToRegE <= issueD && ctrl.memToReg;
            aluSrcE   <= issueD && ctrl.aluSrc;
            branchE   <= issueD && ctrl.branch;
            jumpE     <= issueD && ctrl.jump;
            if (issueD) begin
                rsValE   <= rf.valueOutput1;
                rtValE   <= rf.valueOutput2;
                immE     <= {{(DATA_W-16){instrD[IMM_HI]}}, instrD[IMM_HI:0]};
                pcPlus4E <= pcPlus4D;
                RtE      <= rtD;
                RdE      <= rdD;
                functE   <= instrD[FUNCT_HI:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            illegalD    <= 1'b0;
            stallCountD <= '0;
        end else begin
            if (fire && ctrl.illegal) begin
                illegalD <= 1'b1;
            end
            if (stallF && (stallCountD != '1)) begin
                stallCountD <= stallCountD + 1'b1;
            end
        end
    end

endmodule

// File: doc/decode_issue_stage.md
Name: decode_issue_stage

Overview:
ID stage of the 5-stage MIPS pipeline. It holds the IF/ID register, decodes the latched instruction, and drives the register file read indices. It stalls fetch while any needed source register has its flag at 0 (write pending), and it drives the regWriteD/regDstD/RtD/RdD hazard-marking inputs of the register file only on the issue cycle. Its output is the ID/EX pipeline register consumed by the execute stage.

Parameters:
DATA_W, 32, datapath width
REG_AW, 5, register index width
CNT_W, 16, stall counter width

Ports:
clk  in  1  pipeline clock
reset  in  1  synchronous, active-high reset
instrF  in  32  fetched instruction
pcPlus4F  in  32  fetch PC+4
validF  in  1  instrF is valid
flushD  in  1  branch/jump taken in EX; kill ID contents
stallF  out  1  hold PC and instrF
index1  out  REG_AW  rs read index to register file
index2  out  REG_AW  rt read index to register file
valueOutput1  in  DATA_W  rs data from register file
valueOutput2  in  DATA_W  rt data from register file
flagOutput1  in  1  rs ready flag (1 = no write pending)
flagOutput2  in  1  rt ready flag
regWriteD  out  1  mark destination pending (issue cycle only)
regDstD  out  1  0 = destination is RtD, 1 = destination is RdD
RtD  out  REG_AW  instr[20:16]
RdD  out  REG_AW  instr[15:11]
validE, regWriteE, regDstE, memReadE, memWriteE, memToRegE, aluSrcE, branchE, jumpE  out  1 each  ID/EX control
rsValE, rtValE, immE, pcPlus4E  out  DATA_W each  ID/EX data; immE is sign-extended instr[15:0]
RtE, RdE  out  REG_AW each  ID/EX destination candidates
functE  out  6  ALU function field
illegalD  out  1  sticky: unknown opcode seen
stallCountD  out  CNT_W  saturating count of stall cycles

Behaviour:
- Reset (synchronous, active-high): IF/ID empty; state EMPTY; all ID/EX outputs 0; illegalD=0; stallCountD=0.
- Supported opcodes:
  - R-type 0x00: reads rs and rt; regDst=1; regWrite=1.
  - addi 0x08: reads rs; aluSrc=1; regWrite=1.
  - lw 0x23: reads rs; memRead=1; memToReg=1; aluSrc=1; regWrite=1.
  - sw 0x2B: reads rs and rt; memWrite=1; aluSrc=1.
  - beq 0x04: reads rs and rt; branch=1.
  - j 0x02: reads nothing; jump=1.
  - Any other opcode: issues as a bubble (validE=0) and sets illegalD.
- index1 = instr[25:21] and index2 = instr[20:16] of the IF/ID instruction, driven combinationally.
- Register 0 never causes a stall, regardless of its flag.
- hazard = valid IF/ID AND ((uses rs AND rs!=0 AND !flagOutput1) OR (uses rt AND rt!=0 AND !flagOutput2)).
- fire = valid IF/ID AND !hazard AND !flushD.
- regWriteD = fire AND decoded regWrite AND dest!=0. It is 0 on every other cycle, so a destination flag is cleared exactly once per instruction.
- stallF = hazard AND !flushD.
- FSM states, evaluated at the clock edge:
  - EMPTY: validF AND !flushD -> FULL (load IF/ID); else stay.
  - FULL: flushD -> EMPTY. hazard -> WAIT (IF/ID held). fire -> FULL if validF, else EMPTY (IF/ID reloaded).
  - WAIT: same transitions as FULL. stallCountD increments each cycle spent in WAIT or entering WAIT, saturating at all-ones.
- ID/EX register: on fire, load all decoded fields, valueOutput1/2, immE and pcPlus4E, and set validE=1. Otherwise load a bubble: validE=0, all control bits 0, data fields hold their previous values.
- Single-cycle decode latency: an instruction issued at edge N appears on the E outputs after edge N.
- flushD and hazard in the same cycle: flush wins; no stall, no issue, no regWriteD.
- Flags freed by a writeback in the same cycle arrive combinationally through the register file, so the issue proceeds that cycle.
- Reset asserted mid-stall: the held instruction is discarded; no regWriteD pulse is emitted.

Decomposition:
- Shared package mips_defs:
  - opcode constants OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J
  - field bit positions
  - state encoding EMPTY/FULL/WAIT
- One combinational sub-module, control_decoder: opcode in; regWrite/regDst/mem*/aluSrc/branch/jump/usesRs/usesRt/illegal out.
- The FSM, IF/ID register and ID/EX register stay in decode_issue_stage.

Test Plan:
- add $3,$1,$2 with flags 1,1: one cycle -> validE=1, regWriteD=1, regDstD=1, RdD=3, rsValE/rtValE match register file data, stallF=0.
- lw $1 issued, then add $3,$1,$2 with flagOutput1=0 for 3 cycles: stallF=1 for 3 cycles, 3 bubbles (validE=0), stallCountD=3, regWriteD=0 during stall; the fourth cycle issues.
- add $3,$0,$2 with flagOutput1=0 (r0): no stall, issues immediately. addi $0,$1,5 -> regWriteD=0.
- Stalled beq with flushD=1 in the same cycle: stallF=0, next validE=0, state EMPTY, no regWriteD.
- opcode 0x3F -> validE=0, illegalD=1, and illegalD stays 1 after a following valid add.
- reset asserted during WAIT: the next cycle has all E outputs 0, stallCountD=0, state EMPTY.
